// File: rtl/mdio_defs.sv
// mdio_defs
// Shared definitions for the Clause-22 MDIO management target: frame field
// codes, field widths and the frame-decoder state encoding.
// No ports; imported by mdio_slave.
package mdio_defs;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int PHYAD_BITS = 5;
  localparam int REGAD_BITS = 5;
  localparam int DATA_BITS  = 16;
  localparam int SKIP_BITS  = 18;

  typedef enum logic [3:0] {
    IDLE,
    ST1,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA,
    SKIP
  } mdio_state_t;

endpackage

// File: rtl/sync_signal.sv
// sync_signal
// Multi-flop synchronizer bringing asynchronous inputs into the clk domain.
// Ports:
//   clk     - destination clock
//   rst     - synchronous active-high reset (clears every stage)
//   in_sig  - asynchronous input bus (WIDTH bits)
//   out_sig - synchronized copy, N clk cycles later
module sync_signal #(
  parameter int WIDTH = 2,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sig,
  output logic [WIDTH-1:0] out_sig
);

  logic [WIDTH-1:0] stages [N];

  // Plain shift chain; stage 0 is the only flop that may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_sig;
      for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_sig = stages[N-1];

endmodule

// File: rtl/mdio_slave.sv
// mdio_slave
// Clause-22 MDIO management target (PHY side). MDC/MDIO are oversampled in the
// clk domain; each synchronized MDC rising edge is one frame bit. Writes end in
// a one-cycle reg_wr_en strobe, reads issue a one-cycle reg_rd_en request and
// the returned word is shifted out on MDIO after the turnaround.
// Optional build macro: MDIO_SLAVE_PRE_SUPPRESS_EN - when defined, a single
// idle 1 before ST is enough (preamble suppression, PREAMBLE_LEN ignored).
// Ports:
//   clk, rst      - system clock (>= 8x MDC), synchronous active-high reset
//   mdc_i, mdio_i - asynchronous MDC and MDIO pad input
//   mdio_o/mdio_t - MDIO drive value / tristate enable (1 = released)
//   reg_addr      - REGAD of the current frame
//   reg_wr_data   - write data, valid with reg_wr_en
//   reg_wr_en     - one-cycle write strobe
//   reg_rd_en     - one-cycle read request
//   reg_rd_data   - read data, sampled 2 clk after reg_rd_en
//   busy          - high from ST detection until the frame ends
//   frame_err     - one-cycle pulse on bad ST, bad OP or foreign PHYAD
module mdio_slave
  import mdio_defs::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd7,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wr_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output logic        frame_err
);

`ifdef MDIO_SLAVE_PRE_SUPPRESS_EN
  localparam logic [5:0] PRE_REQ = 6'd1;
`else
  localparam logic [5:0] PRE_REQ = 6'(PREAMBLE_LEN);
`endif

  localparam logic [4:0] LAST_ADDR_BIT = 5'(PHYAD_BITS - 1);
  localparam logic [4:0] LAST_REG_BIT  = 5'(REGAD_BITS - 1);
  localparam logic [4:0] LAST_DATA_BIT = 5'(DATA_BITS - 1);
  localparam logic [4:0] DRIVEN_BITS   = 5'(DATA_BITS);
  localparam logic [4:0] LAST_SKIP_BIT = 5'(SKIP_BITS - 1);

  logic [1:0]  sync_q;
  logic        mdc_s;
  logic        mdio_s;
  logic        mdc_prev;
  logic        mdc_rise;

  mdio_state_t state;
  logic [4:0]  bit_cnt;
  logic [5:0]  pre_cnt;
  logic [15:0] shift_reg;
  logic        op_read;
  logic        rd_latch;

  sync_signal #(.WIDTH(2), .N(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .in_sig  ({mdc_i, mdio_i}),
    .out_sig (sync_q)
  );

  assign mdc_s    = sync_q[1];
  assign mdio_s   = sync_q[0];
  assign mdc_rise = mdc_s & ~mdc_prev;

  always_ff @(posedge clk) begin
    if (rst) mdc_prev <= 1'b0;
    else     mdc_prev <= mdc_s;
  end

  // Frame decoder. Every output is registered here, so a bit sampled on the
  // rise-detect cycle changes the outputs on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      pre_cnt     <= '0;
      shift_reg   <= '0;
      op_read     <= 1'b0;
      rd_latch    <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_t      <= 1'b1;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      rd_latch  <= reg_rd_en;

      if (mdc_rise) begin
        case (state)
          IDLE: begin
            if (mdio_s) begin
              if (pre_cnt < PRE_REQ) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              // A short run of ones before a 0 is dropped without error.
              if (pre_cnt >= PRE_REQ) state <= ST1;
              pre_cnt <= '0;
            end
          end
          ST1: begin
            bit_cnt <= '0;
            if (mdio_s == ST_CODE[0]) begin
              state <= OP;
              busy  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
          OP: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              op_read <= ({shift_reg[0], mdio_s} == OP_READ);
              if ({shift_reg[0], mdio_s} == OP_WRITE || {shift_reg[0], mdio_s} == OP_READ) begin
                state <= PHYAD;
              end else begin
                frame_err <= 1'b1;
                state     <= SKIP;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          PHYAD: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt == LAST_ADDR_BIT) begin
              bit_cnt <= '0;
              if ({shift_reg[3:0], mdio_s} == PHY_ADDR) begin
                state <= REGAD;
              end else begin
                frame_err <= 1'b1;
                state     <= SKIP;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          REGAD: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt == LAST_REG_BIT) begin
              bit_cnt   <= '0;
              reg_addr  <= {shift_reg[3:0], mdio_s};
              reg_rd_en <= op_read;
              state     <= TA;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          TA: begin
            // Read: the edge ending TA bit 1 drives the 0 of TA bit 2, the
            // edge ending TA bit 2 puts D15 on the wire.
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
              if (op_read) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
              end
            end else if (op_read) begin
              mdio_o    <= shift_reg[15];
              shift_reg <= {shift_reg[14:0], 1'b0};
              bit_cnt   <= 5'd1;
              state     <= RDATA;
            end else begin
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          WDATA: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt == LAST_DATA_BIT) begin
              bit_cnt     <= '0;
              reg_wr_data <= {shift_reg[14:0], mdio_s};
              reg_wr_en   <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          RDATA: begin
            // bit_cnt counts data bits already on the wire.
            if (bit_cnt == DRIVEN_BITS) begin
              bit_cnt <= '0;
              mdio_t  <= 1'b1;
              mdio_o  <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              mdio_o    <= shift_reg[15];
              shift_reg <= {shift_reg[14:0], 1'b0};
              bit_cnt   <= bit_cnt + 5'd1;
            end
          end
          SKIP: begin
            if (bit_cnt == LAST_SKIP_BIT) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Read data arrives two cycles after the request; the next MDC edge is
      // at least eight cycles away, so this never collides with shifting.
      if (rd_latch) shift_reg <= reg_rd_data;
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave
// Directed bench for mdio_slave: a behavioural MDIO master drives frames with
// MDC = clk/10, and a negedge monitor logs strobes, errors and bus drive.
// Honours MDIO_SLAVE_PRE_SUPPRESS_EN for the short-preamble expectation.
module tb_mdio_slave;

  logic        clk;
  logic        rst;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] rd_value;
  logic        busy;
  logic        frame_err;

  logic        master_oe;
  logic        master_out;

  int total;
  int bad;
  int wr_cnt;
  int rd_cnt;
  int err_cnt;
  int both_cnt;
  int drv_cnt;
  logic busy_seen;
  logic [4:0]  last_rd_addr;
  logic [4:0]  wr_addr_log[$];
  logic [15:0] wr_data_log[$];

  logic [15:0] rdata;
  logic        ta2;
  int          wr_before;
  int          rd_before;
  int          err_before;
  logic [4:0]  bb_addr [6];
  logic [15:0] bb_data [6];

  mdio_slave dut (
    .clk         (clk),
    .rst         (rst),
    .mdc_i       (mdc),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_t      (mdio_t),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (rd_value),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  // Open-drain style bus with a pull-up: slave wins when it drives.
  assign mdio_i = !mdio_t ? mdio_o : (master_oe ? master_out : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event logger, sampled away from the active clock edge.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (reg_wr_en) begin
      wr_cnt++;
      wr_addr_log.push_back(reg_addr);
      wr_data_log.push_back(reg_wr_data);
    end
    if (reg_rd_en) begin
      rd_cnt++;
      last_rd_addr = reg_addr;
    end
    if (frame_err) err_cnt++;
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One MDC period: falling edge with new master data, sample just before rise.
  task automatic mdc_bit(input logic oe, input logic val, output logic smp);
    @(negedge clk);
    mdc        = 1'b0;
    master_oe  = oe;
    master_out = val;
    repeat (4) @(negedge clk);
    smp = mdio_i;
    if (!mdio_t) drv_cnt++;
    @(negedge clk);
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Full frame from the master; abort_at < 16 stops a read before that data bit.
  task automatic apply_stimulus(input int pre_len, input logic is_read, input logic [4:0] phy,
                                input logic [4:0] regad, input logic [15:0] wdata,
                                input int abort_at, output logic [15:0] rd, output logic ta_bit);
    logic s;
    int   n;
    rd        = '0;
    ta_bit    = 1'b1;
    drv_cnt   = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < pre_len; i++) mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, 1'b0, s);
    mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, is_read, s);
    mdc_bit(1'b1, !is_read, s);
    for (int i = 4; i >= 0; i--) mdc_bit(1'b1, phy[i], s);
    for (int i = 4; i >= 0; i--) mdc_bit(1'b1, regad[i], s);
    if (!is_read) begin
      mdc_bit(1'b1, 1'b1, s);
      mdc_bit(1'b1, 1'b0, s);
      for (int i = 15; i >= 0; i--) mdc_bit(1'b1, wdata[i], s);
    end else begin
      mdc_bit(1'b0, 1'b1, s);
      mdc_bit(1'b0, 1'b1, ta_bit);
      n = (abort_at < 16) ? abort_at : 16;
      for (int i = 0; i < n; i++) begin
        mdc_bit(1'b0, 1'b1, s);
        rd[15-i] = s;
      end
    end
    if (!(is_read && abort_at < 16)) begin
      mdc_bit(1'b1, 1'b1, s);
      mdc_bit(1'b1, 1'b1, s);
    end
  endtask

  initial begin
    total = 0; bad = 0; wr_cnt = 0; rd_cnt = 0; err_cnt = 0; both_cnt = 0; drv_cnt = 0;
    busy_seen = 1'b0; last_rd_addr = '0;
    mdc = 1'b0; master_oe = 1'b0; master_out = 1'b1; rd_value = 16'h0000;
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_mdio_t", 32'(mdio_t), 32'h1);
    check_output("rst_mdio_o", 32'(mdio_o), 32'h1);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_reg_addr", 32'(reg_addr), 32'h0);
    check_output("rst_wr_data", 32'(reg_wr_data), 32'h0);
    check_output("rst_strobes", 32'({reg_wr_en, reg_rd_en, frame_err}), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] write PHY 7 reg 04");
    apply_stimulus(32, 1'b0, 5'd7, 5'h04, 16'h0DE1, 16, rdata, ta2);
    check_output("wr_count", 32'(wr_cnt), 32'd1);
    check_output("wr_addr", 32'(reg_addr), 32'h04);
    check_output("wr_data", 32'(reg_wr_data), 32'h0DE1);
    check_output("wr_no_drive", 32'(drv_cnt), 32'd0);
    check_output("wr_busy_seen", 32'(busy_seen), 32'h1);
    check_output("wr_busy_end", 32'(busy), 32'h0);
    check_output("wr_no_read", 32'(rd_cnt), 32'd0);

    $display("[TB] read PHY 7 reg 02");
    rd_value = 16'h0141;
    apply_stimulus(32, 1'b1, 5'd7, 5'h02, 16'h0000, 16, rdata, ta2);
    check_output("rd_count", 32'(rd_cnt), 32'd1);
    check_output("rd_addr", 32'(last_rd_addr), 32'h02);
    check_output("rd_data", 32'(rdata), 32'h0141);
    check_output("rd_ta_zero", 32'(ta2), 32'h0);
    check_output("rd_drive_bits", 32'(drv_cnt), 32'd17);
    check_output("rd_release", 32'(mdio_t), 32'h1);
    check_output("rd_busy_end", 32'(busy), 32'h0);
    check_output("rd_no_write", 32'(wr_cnt), 32'd1);

    $display("[TB] write to foreign PHY 3");
    apply_stimulus(32, 1'b0, 5'd3, 5'h00, 16'h9140, 16, rdata, ta2);
    check_output("wa_frame_err", 32'(err_cnt), 32'd1);
    check_output("wa_no_write", 32'(wr_cnt), 32'd1);
    check_output("wa_no_drive", 32'(drv_cnt), 32'd0);
    apply_stimulus(32, 1'b0, 5'd7, 5'h00, 16'h9140, 16, rdata, ta2);
    check_output("wa_next_count", 32'(wr_cnt), 32'd2);
    check_output("wa_next_data", 32'(reg_wr_data), 32'h9140);
    check_output("wa_next_addr", 32'(reg_addr), 32'h00);

    $display("[TB] short preamble");
    apply_stimulus(20, 1'b0, 5'd7, 5'h05, 16'hBEEF, 16, rdata, ta2);
`ifdef MDIO_SLAVE_PRE_SUPPRESS_EN
    check_output("sp_write_count", 32'(wr_cnt), 32'd3);
    check_output("sp_write_data", 32'(reg_wr_data), 32'hBEEF);
`else
    check_output("sp_write_count", 32'(wr_cnt), 32'd2);
    check_output("sp_write_data", 32'(reg_wr_data), 32'h9140);
`endif
    check_output("sp_no_err", 32'(err_cnt), 32'd1);

    $display("[TB] reset during read data");
    wr_before = wr_cnt;
    rd_value  = 16'h0141;
    apply_stimulus(32, 1'b1, 5'd7, 5'h02, 16'h0000, 7, rdata, ta2);
    check_output("mr_driving", 32'(mdio_t), 32'h0);
    rd_before = rd_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_output("mr_release", 32'(mdio_t), 32'h1);
    check_output("mr_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_output("mr_no_strobe", 32'(rd_cnt - rd_before + wr_cnt - wr_before), 32'd0);
    apply_stimulus(32, 1'b1, 5'd7, 5'h02, 16'h0000, 16, rdata, ta2);
    check_output("mr_reread_data", 32'(rdata), 32'h0141);
    check_output("mr_reread_count", 32'(rd_cnt - rd_before), 32'd1);

    $display("[TB] back-to-back init writes");
    bb_addr = '{5'h04, 5'h09, 5'h16, 5'h10, 5'h00, 5'h00};
    bb_data = '{16'h0DE1, 16'h0300, 16'h0000, 16'h7800, 16'h1340, 16'h9140};
    wr_addr_log.delete();
    wr_data_log.delete();
    err_before = err_cnt;
    for (int k = 0; k < 6; k++)
      apply_stimulus(32, 1'b0, 5'd7, bb_addr[k], bb_data[k], 16, rdata, ta2);
    check_output("bb_count", 32'(wr_addr_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < wr_addr_log.size()) begin
        check_output($sformatf("bb_addr%0d", k), 32'(wr_addr_log[k]), 32'(bb_addr[k]));
        check_output($sformatf("bb_data%0d", k), 32'(wr_data_log[k]), 32'(bb_data[k]));
      end
    end
    check_output("bb_no_err", 32'(err_cnt - err_before), 32'd0);
    check_output("never_concurrent", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
